multicycle_control: RTL

- Multi-cycle successor to the single-cycle opcode/funct decoder: an FSM that sequences each MIPS instruction over 3-5 cycles.
- Sits between the instruction register and the shared-memory multi-cycle datapath.
- Stretches memory states through a mem_ready handshake and counts retired instructions.
- Instruction set: R-type add/sub/and/or/xor/slt/sll/srl/jr/jalr; lw, sw, beq, bne, j, jal, addi, andi, ori, xori, slti, lui.

---
 rtl/mc_ctrl_pkg.sv | 20 ++
 rtl/mc_alu_op_decode.sv | 23 ++
 rtl/multicycle_control.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcode/funct codes, ALU and mux encodings, FSM state codes for multicycle_control
package mc_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_JALR = 6'h09;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26, F_SLT = 6'h2a;
  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010, ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SHIFT = 3'b101, ALU_SUB = 3'b110, ALU_SLT = 3'b111;
  localparam logic [1:0] PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10, PCS_RS = 2'b11;
  localparam logic [1:0] SRCB_RT = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_BR = 2'b11;
  localparam logic [3:0] S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7;
  localparam logic [3:0] S_RWB = 4'd8, S_IEXEC = 4'd9, S_IWB = 4'd10, S_BRANCH = 4'd11;
  localparam logic [3:0] S_JUMP = 4'd12, S_JR = 4'd13, S_EXC = 4'd14;
  function automatic logic is_r_alu(input logic [5:0] f);
    return f inside {F_SLL, F_SRL, F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLT};
  endfunction
endpackage

// File: rtl/mc_alu_op_decode.sv
// mc_alu_op_decode: opcode/funct -> ALUOp and operand modifiers for EXEC and IEXEC
import mc_ctrl_pkg::*;
module mc_alu_op_decode (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       zext,
  output logic       lui,
  output logic       shift
);
  logic [2:0] r_op, i_op;
  always_comb begin
    r_op = funct == F_SUB ? ALU_SUB : funct == F_AND ? ALU_AND : funct == F_OR ? ALU_OR :
           funct == F_XOR ? ALU_XOR : funct == F_SLT ? ALU_SLT :
           (funct == F_SLL || funct == F_SRL) ? ALU_SHIFT : ALU_ADD;
    i_op = opcode == OP_ANDI ? ALU_AND : opcode == OP_ORI ? ALU_OR :
           opcode == OP_XORI ? ALU_XOR : opcode == OP_SLTI ? ALU_SLT : ALU_ADD;
    alu_op = opcode == OP_RTYPE ? r_op : i_op;
    zext = opcode inside {OP_ANDI, OP_ORI, OP_XORI};
    lui = opcode == OP_LUI;
    shift = opcode == OP_RTYPE && (funct == F_SLL || funct == F_SRL);
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM with mem_ready stalls and retire counter; MC_ILLEGAL_TRAP_EN adds sticky EXC state
import mc_ctrl_pkg::*;
module multicycle_control #(
  parameter int CNT_W   = 32,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               BNE,
  output logic [1:0]         PCSource,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               MemtoReg,
  output logic               Jal,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUOp,
  output logic               signal,
  output logic               LUI,
  output logic               shift,
  output logic [CNT_W-1:0]   instr_retired,
  output logic [STATE_W-1:0] dbg_state
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic               illegal_instr
`endif
);
`ifdef MC_ILLEGAL_TRAP_EN
  localparam logic [3:0] S_ILL = S_EXC;
`else
  localparam logic [3:0] S_ILL = S_FETCH;
`endif
  logic [3:0] state_q, state_d, dispatch;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] dec_alu_op;
  logic dec_zext, dec_lui, dec_shift;
  mc_alu_op_decode u_alu_dec (
    .opcode(opcode), .funct(funct), .alu_op(dec_alu_op),
    .zext(dec_zext), .lui(dec_lui), .shift(dec_shift)
  );
  always_comb begin
    dispatch = S_ILL;
    case (opcode)
      OP_LW, OP_SW: dispatch = S_MEMADR;
      OP_RTYPE: dispatch = (funct == F_JR || funct == F_JALR) ? S_JR : is_r_alu(funct) ? S_EXEC : S_ILL;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI: dispatch = S_IEXEC;
      OP_BEQ, OP_BNE: dispatch = S_BRANCH;
      OP_J, OP_JAL: dispatch = S_JUMP;
      default: dispatch = S_ILL;
    endcase
  end
  always_comb begin
    state_d = state_q;
    {PCWrite, PCWriteCond, BNE, PCSource, IorD, MemRead, MemWrite, IRWrite, RegDst, RegWrite,
     MemtoReg, Jal, ALUSrcA, ALUSrcB, ALUOp, signal, LUI, shift} = '0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_4;
        ALUOp = ALU_ADD;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_BR;
        ALUOp = ALU_ADD;
        state_d = dispatch;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp = ALU_ADD;
        state_d = opcode == OP_LW ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
        state_d = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_RT;
        ALUOp = dec_alu_op;
        shift = dec_shift;
        state_d = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst = 1'b1;
        state_d = S_FETCH;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp = dec_alu_op;
        signal = dec_zext;
        LUI = dec_lui;
        state_d = S_IWB;
      end
      S_IWB: begin
        RegWrite = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_RT;
        ALUOp = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource = PCS_ALUOUT;
        BNE = opcode == OP_BNE;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSource = PCS_JUMP;
        RegWrite = opcode == OP_JAL;
        Jal = opcode == OP_JAL;
        state_d = S_FETCH;
      end
      S_JR: begin
        PCWrite = 1'b1;
        PCSource = PCS_RS;
        RegWrite = funct == F_JALR;
        RegDst = funct == F_JALR;
        Jal = funct == F_JALR;
        state_d = S_FETCH;
      end
      S_EXC: state_d = S_EXC;
      default: state_d = S_RST;
    endcase
  end
  // Holding in FETCH on a stall is not a new entry, so it does not count.
  always_comb cnt_d = (state_d == S_FETCH && state_q != S_FETCH && state_q != S_RST) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign instr_retired = cnt_q;
  assign dbg_state = STATE_W'(state_q);
`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_instr = state_q == S_EXC;
`endif
endmodule
